mem_stage: RTL and testbench

Memory stage of the five-stage pipeline, sitting directly upstream of the write-back stage. It performs data-memory reads and writes through a multi-cycle request/acknowledge port, stalls the upstream stage while an access is outstanding, and registers the fields write-back consumes. Those fields are the memory data, ALU result, MemToReg, jump address, branch-or-PC value and Jump. It also flags unaligned accesses, conflicting controls and memory timeouts.

---
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with multi-cycle data-memory port
// Non-memory and illegal ops pass straight to write-back; legal loads/stores
// hold the upstream stage via stall until mem_ack or timeout abort.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg_in,
  input  logic        Jump_in,
  input  logic [15:0] jumpAddr_in,
  input  logic [15:0] branch_or_pc_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [15:0] mem_data,
  output logic [15:0] ALU_result,
  output logic [15:0] jumpAddr,
  output logic [15:0] branch_or_pc,
  output logic        MemToReg,
  output logic        Jump,
  output logic        err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt;
  logic        cap_read, cap_mtr, cap_jump;
  logic [15:0] cap_jaddr, cap_bpc;

  logic is_mem, bad_op, legal_mem;
  logic do_pass, do_accept, do_done, do_abort, do_count;

  assign is_mem    = MemRead | MemWrite;
  assign bad_op    = (MemRead & MemWrite) | (is_mem & addr[0]);
  assign legal_mem = is_mem & ~bad_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    do_pass   = 1'b0;
    do_accept = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    do_count  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (legal_mem) begin
            stall     = 1'b1;
            do_accept = 1'b1;
            state_d   = BUSY;
          end else begin
            do_pass = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          do_done = 1'b1;
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          // abort releases the upstream in the same cycle as a normal ack would
          do_abort = 1'b1;
          state_d  = IDLE;
        end else begin
          stall    = 1'b1;
          do_count = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cnt          <= '0;
      cap_read     <= 1'b0;
      cap_mtr      <= 1'b0;
      cap_jump     <= 1'b0;
      cap_jaddr    <= '0;
      cap_bpc      <= '0;
      out_valid    <= 1'b0;
      mem_data     <= '0;
      ALU_result   <= '0;
      jumpAddr     <= '0;
      branch_or_pc <= '0;
      MemToReg     <= 1'b0;
      Jump         <= 1'b0;
      err          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (do_pass) begin
        out_valid    <= 1'b1;
        ALU_result   <= addr;
        mem_data     <= '0;
        err          <= bad_op;
        MemToReg     <= MemToReg_in;
        Jump         <= Jump_in;
        jumpAddr     <= jumpAddr_in;
        branch_or_pc <= branch_or_pc_in;
      end
      if (do_accept) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite;
        mem_addr  <= addr;
        mem_wdata <= wr_data;
        cnt       <= '0;
        cap_read  <= MemRead;
        cap_mtr   <= MemToReg_in;
        cap_jump  <= Jump_in;
        cap_jaddr <= jumpAddr_in;
        cap_bpc   <= branch_or_pc_in;
      end
      if (do_count) cnt <= cnt + 8'd1;
      if (do_done || do_abort) begin
        mem_req      <= 1'b0;
        mem_we       <= 1'b0;
        out_valid    <= 1'b1;
        ALU_result   <= mem_addr;
        mem_data     <= (do_done && cap_read) ? mem_rdata : 16'h0000;
        err          <= do_abort;
        MemToReg     <= cap_mtr;
        Jump         <= cap_jump;
        jumpAddr     <= cap_jaddr;
        branch_or_pc <= cap_bpc;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, MemRead, MemWrite, MemToReg_in, Jump_in;
  logic [15:0] addr, wr_data, jumpAddr_in, branch_or_pc_in;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        out_valid, MemToReg, Jump, err;
  logic [15:0] mem_data, ALU_result, jumpAddr, branch_or_pc;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .addr(addr), .wr_data(wr_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg_in(MemToReg_in),
    .Jump_in(Jump_in), .jumpAddr_in(jumpAddr_in), .branch_or_pc_in(branch_or_pc_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .mem_data(mem_data), .ALU_result(ALU_result),
    .jumpAddr(jumpAddr), .branch_or_pc(branch_or_pc), .MemToReg(MemToReg),
    .Jump(Jump), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] md, alu, ja, bpc;
    logic        mtr, jmp, er;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // result monitor: out_valid must appear exactly in the cycle the scoreboard predicts
  always @(negedge clk) begin
    exp_t e;
    bit   due;
    if (rst) begin
      due = (sb.size() > 0) && (sb[0].due == cyc);
      if (out_valid || due) begin
        check("out_valid", 32'(out_valid), 32'(due));
        if (due) begin
          e = sb.pop_front();
          if (out_valid) begin
            check("mem_data",     32'(mem_data),     32'(e.md));
            check("ALU_result",   32'(ALU_result),   32'(e.alu));
            check("jumpAddr",     32'(jumpAddr),     32'(e.ja));
            check("branch_or_pc", 32'(branch_or_pc), 32'(e.bpc));
            check("MemToReg",     32'(MemToReg),     32'(e.mtr));
            check("Jump",         32'(Jump),         32'(e.jmp));
            check("err",          32'(err),          32'(e.er));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ack_k: request cycle carrying mem_ack; 0 or >TO means never acked
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic mtr, input logic jmp, input logic [15:0] ja, input logic [15:0] bpc,
                       input int ack_k, input logic [15:0] rdata);
    logic bad, legal, tout;
    int   k;
    exp_t e;
    bad   = (rd & wr) | ((rd | wr) & a[0]);
    legal = (rd | wr) & ~bad;
    tout  = legal && (ack_k < 1 || ack_k > TO);
    k     = tout ? TO : ack_k;
    in_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wr_data = wd;
    MemToReg_in = mtr; Jump_in = jmp; jumpAddr_in = ja; branch_or_pc_in = bpc;
    e.md  = (legal && rd && !tout) ? rdata : 16'h0000;
    e.alu = a; e.ja = ja; e.bpc = bpc; e.mtr = mtr; e.jmp = jmp;
    e.er  = bad | tout;
    e.due = cyc + 1 + (legal ? k : 0);
    sb.push_back(e);
    @(negedge clk);
    check("stall_accept", 32'(stall), 32'(legal));
    check("req_accept", 32'(mem_req), 32'(0));
    @(posedge clk); #1;
    if (legal) begin
      addr = ~a; wr_data = ~wd; MemRead = wr; MemWrite = rd;
      MemToReg_in = ~mtr; Jump_in = ~jmp; jumpAddr_in = ~ja; branch_or_pc_in = ~bpc;
      for (int i = 1; i <= k; i++) begin
        mem_ack   = (i == ack_k);
        mem_rdata = (i == ack_k) ? rdata : 16'($urandom);
        @(negedge clk);
        check("mem_req", 32'(mem_req), 32'(1));
        check("mem_addr", 32'(mem_addr), 32'(a));
        check("mem_we", 32'(mem_we), 32'(wr));
        check("mem_wdata", 32'(mem_wdata), 32'(wd));
        check("stall_busy", 32'(stall), 32'(i < k));
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
  endtask

  initial begin
    logic r, w;
    logic [15:0] a;
    rst = 1'b1;
    in_valid = 0; MemRead = 0; MemWrite = 0; MemToReg_in = 0; Jump_in = 0;
    addr = 0; wr_data = 0; jumpAddr_in = 0; branch_or_pc_in = 0;
    mem_ack = 0; mem_rdata = 0;
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_alu", 32'(ALU_result), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    idle(1);

    // non-memory op with a stray mem_ack that must not matter
    mem_ack = 1'b1;
    do_op(0, 0, 16'h1234, 16'h0, 0, 1, 16'h0040, 16'h0100, 0, 16'h0);
    mem_ack = 1'b0;
    idle(1);
    do_op(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0200, 16'h0300, 3, 16'hBEEF);
    idle(2);
    // store then back-to-back load
    do_op(0, 1, 16'h0020, 16'h5A5A, 0, 0, 16'h0400, 16'h0500, 1, 16'h0);
    do_op(1, 0, 16'h0030, 16'h0, 1, 1, 16'h0600, 16'h0700, 2, 16'h1357);
    idle(1);
    do_op(1, 0, 16'h0011, 16'h0, 1, 0, 16'h0800, 16'h0900, 1, 16'hAAAA);
    do_op(1, 1, 16'h0040, 16'h1111, 0, 1, 16'h0A00, 16'h0B00, 1, 16'hAAAA);
    idle(1);
    // timeout then return to normal operation
    do_op(1, 0, 16'h0050, 16'h0, 1, 0, 16'h0C00, 16'h0D00, 0, 16'h0);
    do_op(0, 0, 16'h0055, 16'h0, 0, 0, 16'h0E00, 16'h0F00, 0, 16'h0);

    for (int n = 0; n < 12; n++) begin
      r = 1'($urandom); w = 1'($urandom);
      a = 16'($urandom);
      if ($urandom_range(3) != 0) a[0] = 1'b0;
      do_op(r, w, a, 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
            16'($urandom), int'($urandom_range(1, 5)), 16'($urandom));
      if (n % 3 == 0) idle(1);
    end

    do_op(0, 0, 16'h7777, 16'h0, 1, 1, 16'h1111, 16'h2222, 0, 16'h0);
    // reset during the second BUSY cycle
    in_valid = 1; MemRead = 1; MemWrite = 0; addr = 16'h0060;
    MemToReg_in = 1; Jump_in = 1; jumpAddr_in = 16'h3333; branch_or_pc_in = 16'h4444;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 0; MemRead = 0;
    rst = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'(0));
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_alu", 32'(ALU_result), 32'(0));
    check("arst_jumpAddr", 32'(jumpAddr), 32'(0));
    check("arst_Jump", 32'(Jump), 32'(0));
    check("arst_mem_addr", 32'(mem_addr), 32'(0));
    @(posedge clk); #1 mem_ack = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(mem_req), 32'(0));
    @(posedge clk); #1 mem_ack = 1'b0;
    idle(3);
    do_op(0, 0, 16'h4321, 16'h0, 0, 1, 16'h0044, 16'h0088, 0, 16'h0);
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
